// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with per-register pending (scoreboard) bits
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset; clears data and pending bits
//   we         in   write enable
//   rd         in   write index
//   result     in   write data
//   rs, rt     in   read indices for ports A and B
//   claim      in   mark register claim_idx as pending a write
//   claim_idx  in   register to mark pending
//   a, b       out  combinational read data for ports A and B
//   a_busy     out  register rs is pending
//   b_busy     out  register rt is pending
//   regs_flat  out  stored registers, register i at [i*WIDTH +: WIDTH]
//   busy_vec   out  stored pending bit of each register
module regfile_2r1w #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          rd,
    input  logic [WIDTH-1:0]       result,
    input  logic [AW-1:0]          rs,
    input  logic [AW-1:0]          rt,
    input  logic                   claim,
    input  logic [AW-1:0]          claim_idx,
    output logic [WIDTH-1:0]       a,
    output logic [WIDTH-1:0]       b,
    output logic                   a_busy,
    output logic                   b_busy,
    output logic [DEPTH*WIDTH-1:0] regs_flat,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [WIDTH-1:0] regs_q    [DEPTH];
    logic [WIDTH-1:0] regs_d    [DEPTH];
    logic [WIDTH-1:0] regs_view [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] busy_view;
    logic             wr_en;
    logic             claim_en;

    // Qualified write/claim: the index must name an existing register, and
    // register 0 is not writable or claimable when it is hard-wired to zero.
    // wr_en deliberately ignores rst so bypass still forwards during reset.
    always_comb begin
        wr_en    = 1'b0;
        claim_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd == AW'(i)) begin
                wr_en = we;
            end
            if (claim_idx == AW'(i)) begin
                claim_en = claim;
            end
        end
        if (ZERO_R0 != 0 && rd == '0) begin
            wr_en = 1'b0;
        end
        if (ZERO_R0 != 0 && claim_idx == '0) begin
            claim_en = 1'b0;
        end
    end

    // Next state. The claim is applied after the write so that a same-edge
    // claim and write to one register leaves it pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && rd == AW'(i)) begin
                regs_d[i] = result;
                busy_d[i] = 1'b0;
            end
            if (claim_en && claim_idx == AW'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Visible stored state: forced to zero while reset is asserted, and
    // register 0 masked when hard-wired, so nothing undefined leaks out.
    always_comb begin
        busy_view = rst ? '0 : busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_view[i] = rst ? '0 : regs_q[i];
        end
        if (ZERO_R0 != 0) begin
            regs_view[0] = '0;
            busy_view[0] = 1'b0;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            regs_flat[i*WIDTH +: WIDTH] = regs_view[i];
        end
    end

    assign busy_vec = busy_view;

    // Read ports. An index with no matching register falls through to zero.
    always_comb begin
        a      = '0;
        b      = '0;
        a_busy = 1'b0;
        b_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rs == AW'(i)) begin
                a      = regs_view[i];
                a_busy = busy_view[i];
            end
            if (rt == AW'(i)) begin
                b      = regs_view[i];
                b_busy = busy_view[i];
            end
        end
        if (BYPASS != 0 && wr_en) begin
            if (rd == rs) begin
                a      = result;
                a_busy = 1'b0;
            end
            if (rd == rt) begin
                b      = result;
                b_busy = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - bench for regfile_2r1w across bypass, no-bypass and zero-r0/depth-5 builds
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, claim;
    logic [2:0]  rd, rs, rt, cidx;
    logic [15:0] result;
    logic        chk_en;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] u0_a, u0_b, u1_a, u1_b, u2_a, u2_b;
    logic        u0_ab, u0_bb, u1_ab, u1_bb, u2_ab, u2_bb;
    logic [63:0] u0_flat, u1_flat;
    logic [79:0] u2_flat;
    logic [3:0]  u0_bv, u1_bv;
    logic [4:0]  u2_bv;

    regfile_2r1w #(.WIDTH(16), .DEPTH(4), .BYPASS(1), .ZERO_R0(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .rd(rd[1:0]), .result(result),
        .rs(rs[1:0]), .rt(rt[1:0]), .claim(claim), .claim_idx(cidx[1:0]),
        .a(u0_a), .b(u0_b), .a_busy(u0_ab), .b_busy(u0_bb),
        .regs_flat(u0_flat), .busy_vec(u0_bv)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(4), .BYPASS(0), .ZERO_R0(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .rd(rd[1:0]), .result(result),
        .rs(rs[1:0]), .rt(rt[1:0]), .claim(claim), .claim_idx(cidx[1:0]),
        .a(u1_a), .b(u1_b), .a_busy(u1_ab), .b_busy(u1_bb),
        .regs_flat(u1_flat), .busy_vec(u1_bv)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(5), .BYPASS(1), .ZERO_R0(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .rd(rd), .result(result),
        .rs(rs), .rt(rt), .claim(claim), .claim_idx(cidx),
        .a(u2_a), .b(u2_b), .a_busy(u2_ab), .b_busy(u2_bb),
        .regs_flat(u2_flat), .busy_vec(u2_bv)
    );

    // Behavioural model: plain arrays per instance, updated from the rules.
    int          m_depth [3] = '{4, 4, 5};
    int          m_byp   [3] = '{1, 0, 1};
    int          m_zero  [3] = '{0, 0, 1};
    int          m_mask  [3] = '{3, 3, 7};
    logic [15:0] mregs   [3][8];
    bit          mbusy   [3][8];

    function automatic bit wr_ok(int k);
        int r;
        r = int'(rd) & m_mask[k];
        return we && (r < m_depth[k]) && !(m_zero[k] != 0 && r == 0);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int r, c;
            r = int'(rd) & m_mask[k];
            c = int'(cidx) & m_mask[k];
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    mregs[k][i] = 16'h0;
                    mbusy[k][i] = 1'b0;
                end
            end else begin
                if (wr_ok(k)) begin
                    mregs[k][r] = result;
                    mbusy[k][r] = 1'b0;
                end
                if (claim && c < m_depth[k] && !(m_zero[k] != 0 && c == 0)) begin
                    mbusy[k][c] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) model_edge();

    function automatic logic [16:0] m_read(int k, int idx_in);
        logic [15:0] d;
        bit          bz;
        int          idx;
        idx = idx_in & m_mask[k];
        d   = 16'h0;
        bz  = 1'b0;
        if (idx < m_depth[k] && !(m_zero[k] != 0 && idx == 0)) begin
            d  = mregs[k][idx];
            bz = mbusy[k][idx];
        end
        if (rst) begin
            d  = 16'h0;
            bz = 1'b0;
        end
        if (m_byp[k] != 0 && wr_ok(k) && (int'(rd) & m_mask[k]) == idx) begin
            d  = result;
            bz = 1'b0;
        end
        return {bz, d};
    endfunction

    function automatic logic [127:0] m_flat(int k);
        logic [127:0] f;
        f = '0;
        if (!rst) begin
            for (int i = 0; i < m_depth[k]; i++) begin
                if (!(m_zero[k] != 0 && i == 0)) f[i*16 +: 16] = mregs[k][i];
            end
        end
        return f;
    endfunction

    function automatic logic [7:0] m_bvec(int k);
        logic [7:0] v;
        v = '0;
        if (!rst) begin
            for (int i = 0; i < m_depth[k]; i++) begin
                if (!(m_zero[k] != 0 && i == 0)) v[i] = mbusy[k][i];
            end
        end
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_inst(int k, logic [15:0] av, logic [15:0] bv, logic ab, logic bb,
                              logic [127:0] fl, logic [7:0] bvec);
        logic [16:0] ea, eb;
        ea = m_read(k, int'(rs));
        eb = m_read(k, int'(rt));
        check($sformatf("u%0d.a", k), av, ea[15:0]);
        check($sformatf("u%0d.b", k), bv, eb[15:0]);
        check($sformatf("u%0d.a_busy", k), ab, ea[16]);
        check($sformatf("u%0d.b_busy", k), bb, eb[16]);
        check($sformatf("u%0d.regs_flat", k), fl, m_flat(k));
        check($sformatf("u%0d.busy_vec", k), bvec, m_bvec(k));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, u0_a, u0_b, u0_ab, u0_bb, u0_flat, u0_bv);
            check_inst(1, u1_a, u1_b, u1_ab, u1_bb, u1_flat, u1_bv);
            check_inst(2, u2_a, u2_b, u2_ab, u2_bb, u2_flat, u2_bv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [2:0] idx, logic [15:0] data);
        we = 1'b1; rd = idx; result = data;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; claim = 1'b0; chk_en = 1'b0;
        rd = '0; rs = '0; rt = '0; cidx = '0; result = '0;
        #2;
        check("rst_during_flat", u0_flat, 0);
        check("rst_during_busy", u0_bv, 0);
        tick();
        rst = 1'b0; chk_en = 1'b1;
        #2;
        check("rst_after_flat", u0_flat, 0);
        check("rst_after_busy", u0_bv, 0);
        check("rst_after_u2_flat", u2_flat, 0);

        wr(3'd0, 16'hAAAA); wr(3'd1, 16'hBBBB); wr(3'd2, 16'hCCCC); wr(3'd3, 16'hDDDD);
        #2;
        check("fill_flat", u0_flat, 64'hDDDD_CCCC_BBBB_AAAA);
        check("fill_busy", u0_bv, 0);
        check("fill_u2_flat", u2_flat, 80'h0000_DDDD_CCCC_BBBB_0000);

        rs = 3'd1; rt = 3'd3; #2;
        check("dual_a", u0_a, 16'hBBBB);
        check("dual_b", u0_b, 16'hDDDD);
        rs = 3'd2; rt = 3'd2; #2;
        check("same_a", u0_a, 16'hCCCC);
        check("same_b", u0_b, 16'hCCCC);

        we = 1'b1; rd = 3'd2; result = 16'h1234; #2;
        check("byp_a", u0_a, 16'h1234);
        check("nobyp_a_before", u1_a, 16'hCCCC);
        tick(); we = 1'b0; #2;
        check("nobyp_a_after", u1_a, 16'h1234);

        claim = 1'b1; cidx = 3'd1; tick(); claim = 1'b0; rs = 3'd1; #2;
        check("claim_a_busy", u0_ab, 1);
        check("claim_busy_vec", u0_bv, 4'b0010);
        we = 1'b1; rd = 3'd1; result = 16'h5555; #2;
        check("byp_busy_zero", u0_ab, 0);
        check("byp_a_5555", u0_a, 16'h5555);
        check("nobyp_busy_held", u1_ab, 1);
        tick(); we = 1'b0; #2;
        check("write_clears_busy", u0_bv, 0);
        check("nobyp_a_5555", u1_a, 16'h5555);
        we = 1'b1; rd = 3'd1; result = 16'h5555; claim = 1'b1; cidx = 3'd1;
        tick(); we = 1'b0; claim = 1'b0; #2;
        check("claim_wins_data", u0_a, 16'h5555);
        check("claim_wins_busy", u0_ab, 1);

        we = 1'b1; rd = 3'd0; result = 16'h7777; claim = 1'b1; cidx = 3'd3;
        tick(); we = 1'b0; #2;
        check("indep_busy", u0_bv, 4'b1010);
        check("indep_flat", u0_flat, 64'hDDDD_1234_5555_7777);
        cidx = 3'd1; tick(); claim = 1'b0; #2;
        check("reclaim_busy", u0_bv, 4'b1010);

        we = 1'b1; rd = 3'd0; result = 16'hFFFF; rs = 3'd0; #2;
        check("z0_nobyp", u2_a, 0);
        check("z0_u0_byp", u0_a, 16'hFFFF);
        tick(); we = 1'b0; #2;
        check("z0_read", u2_a, 0);
        claim = 1'b1; cidx = 3'd0; tick(); claim = 1'b0; #2;
        check("z0_claim_busy", u2_bv, 5'b01010);
        check("u0_claim_r0", u0_bv, 4'b1011);

        we = 1'b1; rd = 3'd7; result = 16'hABCD; rs = 3'd7; rt = 3'd4; #2;
        check("oor_u2_a", u2_a, 0);
        check("oor_u2_busy", u2_ab, 0);
        check("alias_u0_a", u0_a, 16'hABCD);
        tick(); we = 1'b0; #2;
        check("oor_u2_flat", u2_flat, 80'h0000_DDDD_1234_5555_0000);
        check("alias_u0_flat", u0_flat, 64'hABCD_1234_5555_FFFF);
        check("alias_u0_busy", u0_bv, 4'b0011);

        we = 1'b1; rd = 3'd1; result = 16'hBBBB; claim = 1'b1; cidx = 3'd1;
        tick(); we = 1'b0; claim = 1'b0; rs = 3'd1; #2;
        check("pre_rst_a", u0_a, 16'hBBBB);
        check("pre_rst_busy", u0_ab, 1);
        rst = 1'b1; we = 1'b1; rd = 3'd3; result = 16'h9999; rs = 3'd3; rt = 3'd1; #2;
        check("rst_byp_a", u0_a, 16'h9999);
        check("rst_nobyp_a", u1_a, 0);
        check("rst_b", u0_b, 0);
        check("rst_mid_flat", u0_flat, 0);
        tick(); rst = 1'b0; we = 1'b0; #2;
        check("post_rst_flat", u0_flat, 0);
        check("post_rst_busy", u0_bv, 0);
        check("post_rst_u1_flat", u1_flat, 0);
        check("post_rst_u2_busy", u2_bv, 0);
        check("post_rst_a", u0_a, 0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
